pc_sequencer: RTL and testbench

Multi-thread program-counter sequencer for each Arya core's fetch stage. Holds one PC per hardware thread, issues one thread's PC per cycle in round-robin order over enabled threads, and auto-increments the issued PC. Accepts jump/call/return redirects from execute, with an optional per-thread return-address stack (RAS).

---
 rtl/pc_seq_pkg.sv | 14 +
 rtl/pc_seq_if.sv | 34 +++
 rtl/pc_ras.sv | 53 +++++
 rtl/pc_sequencer.sv | 126 ++++++++++++
 tb/tb_pc_sequencer.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/pc_seq_pkg.sv
`default_nettype none
// pc_seq_pkg: redirect-kind encodings and thread-id width helper for pc_sequencer.
package pc_seq_pkg;

   localparam logic [1:0] REDIR_JUMP = 2'b00;
   localparam logic [1:0] REDIR_CALL = 2'b01;
   localparam logic [1:0] REDIR_RET  = 2'b10;

   function automatic int tid_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage
`default_nettype wire

// File: rtl/pc_seq_if.sv
`default_nettype none
// pc_seq_if: issue-control, redirect and issued-PC bundle between execute/fetch and pc_sequencer.
interface pc_seq_if #(
   parameter int INST_ADDR_WIDTH = 6,
   parameter int NUM_THREADS     = 4,
   parameter int TID_W           = pc_seq_pkg::tid_w(NUM_THREADS)
);
   logic                       en;
   logic                       stall;
   logic [NUM_THREADS-1:0]     thread_en;
   logic                       redirect_valid;
   logic [TID_W-1:0]           redirect_tid;
   logic [1:0]                 redirect_kind;
   logic [INST_ADDR_WIDTH-1:0] redirect_pc;
   logic [INST_ADDR_WIDTH-1:0] link_pc;
   logic [INST_ADDR_WIDTH-1:0] pc_out;
   logic [TID_W-1:0]           tid_out;
   logic                       pc_valid;
   logic                       ras_overflow;
   logic                       ras_underflow;

   modport master (
      output en, stall, thread_en, redirect_valid, redirect_tid, redirect_kind,
             redirect_pc, link_pc,
      input  pc_out, tid_out, pc_valid, ras_overflow, ras_underflow
   );

   modport slave (
      input  en, stall, thread_en, redirect_valid, redirect_tid, redirect_kind,
             redirect_pc, link_pc,
      output pc_out, tid_out, pc_valid, ras_overflow, ras_underflow
   );
endinterface
`default_nettype wire

// File: rtl/pc_ras.sv
`default_nettype none
// pc_ras: single-thread circular return-address stack; a push when full overwrites the oldest entry.
module pc_ras #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 6
) (
   input  wire logic             clk,
   input  wire logic             reset,
   input  wire logic             push_i,
   input  wire logic             pop_i,
   input  wire logic [WIDTH-1:0] data_i,
   output logic      [WIDTH-1:0] top_o,
   output logic                  empty_o,
   output logic                  full_o
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    ptr_q, ptr_d, top_idx;
   logic [PW:0]      cnt_q, cnt_d;

   assign empty_o = (cnt_q == '0);
   assign full_o  = (cnt_q == (PW+1)'(DEPTH));
   assign top_o   = mem_q[top_idx];

   always_comb begin
      top_idx = (ptr_q == '0) ? PW'(DEPTH - 1) : ptr_q - 1'b1;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      if (push_i) begin
         ptr_d = (int'(ptr_q) == DEPTH - 1) ? '0 : ptr_q + 1'b1;
         if (!full_o) cnt_d = cnt_q + 1'b1;
      end else if (pop_i && !empty_o) begin
         ptr_d = top_idx;
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ptr_q <= '0;
         cnt_q <= '0;
      end else begin
         ptr_q <= ptr_d;
         cnt_q <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_i) mem_q[ptr_q] <= data_i;
   end
endmodule
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// pc_sequencer: round-robin multi-thread PC issue with jump/call/return redirects.
// Define PC_RAS_EN to build per-thread return-address stacks; otherwise call/return act as jump.
module pc_sequencer
   import pc_seq_pkg::*;
#(
   parameter int INST_ADDR_WIDTH = 6,
   parameter int NUM_THREADS     = 4,
   parameter int RAS_DEPTH       = 4,
   parameter int RESET_PC        = 0
) (
   input wire logic clk,
   input wire logic reset,
   pc_seq_if.slave  bus
);
   localparam int TID_W = tid_w(NUM_THREADS);

   logic [INST_ADDR_WIDTH-1:0] pc_q [NUM_THREADS];
   logic [INST_ADDR_WIDTH-1:0] pc_d [NUM_THREADS];
   logic [TID_W-1:0]           last_tid_q, last_tid_d, sel;
   logic [INST_ADDR_WIDTH-1:0] pc_out_q, pc_out_d;
   logic [TID_W-1:0]           tid_out_q, tid_out_d;
   logic                       valid_q, valid_d;
   logic                       ovf_q, ovf_d, unf_q, unf_d;
   logic                       any_en, issue, redir;

   // Scan starts just past last_tid so the previous winner is picked only when it is alone.
   always_comb begin
      sel    = '0;
      any_en = 1'b0;
      for (int i = 1; i <= NUM_THREADS; i++) begin
         if (!any_en && bus.thread_en[(int'(last_tid_q) + i) % NUM_THREADS]) begin
            any_en = 1'b1;
            sel    = TID_W'((int'(last_tid_q) + i) % NUM_THREADS);
         end
      end
   end

   assign issue = bus.en && !bus.stall && any_en;
   assign redir = bus.en && bus.redirect_valid && (int'(bus.redirect_tid) < NUM_THREADS);

`ifdef PC_RAS_EN
   logic [NUM_THREADS-1:0]     ras_push, ras_pop, ras_empty, ras_full;
   logic [INST_ADDR_WIDTH-1:0] ras_top [NUM_THREADS];

   for (genvar t = 0; t < NUM_THREADS; t++) begin : g_ras
      assign ras_push[t] = redir && (int'(bus.redirect_tid) == t) && (bus.redirect_kind == REDIR_CALL);
      assign ras_pop[t]  = redir && (int'(bus.redirect_tid) == t) && (bus.redirect_kind == REDIR_RET);

      pc_ras #(
         .DEPTH (RAS_DEPTH),
         .WIDTH (INST_ADDR_WIDTH)
      ) u_ras (
         .clk     (clk),
         .reset   (reset),
         .push_i  (ras_push[t]),
         .pop_i   (ras_pop[t]),
         .data_i  (bus.link_pc),
         .top_o   (ras_top[t]),
         .empty_o (ras_empty[t]),
         .full_o  (ras_full[t])
      );
   end

   assign ovf_d = |(ras_push & ras_full);
   assign unf_d = |(ras_pop & ras_empty);
`else
   logic unused_ras_inputs;
   assign unused_ras_inputs = ^{bus.link_pc, bus.redirect_kind};
   assign ovf_d = 1'b0;
   assign unf_d = 1'b0;
`endif

   always_comb begin
      pc_d       = pc_q;
      last_tid_d = last_tid_q;
      pc_out_d   = pc_out_q;
      tid_out_d  = tid_out_q;
      valid_d    = 1'b0;
      if (issue) begin
         pc_out_d   = pc_q[sel];
         tid_out_d  = sel;
         valid_d    = 1'b1;
         last_tid_d = sel;
         pc_d[sel]  = pc_q[sel] + 1'b1;
      end
      // Redirect is applied after the increment so its target wins on the same thread.
      for (int t = 0; t < NUM_THREADS; t++) begin
         if (redir && (int'(bus.redirect_tid) == t)) begin
`ifdef PC_RAS_EN
            if (bus.redirect_kind == REDIR_RET && !ras_empty[t]) pc_d[t] = ras_top[t];
            else                                                 pc_d[t] = bus.redirect_pc;
`else
            pc_d[t] = bus.redirect_pc;
`endif
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int t = 0; t < NUM_THREADS; t++) pc_q[t] <= INST_ADDR_WIDTH'(RESET_PC);
         last_tid_q <= TID_W'(NUM_THREADS - 1);
         pc_out_q   <= '0;
         tid_out_q  <= '0;
         valid_q    <= 1'b0;
         ovf_q      <= 1'b0;
         unf_q      <= 1'b0;
      end else begin
         pc_q       <= pc_d;
         last_tid_q <= last_tid_d;
         pc_out_q   <= pc_out_d;
         tid_out_q  <= tid_out_d;
         valid_q    <= valid_d;
         ovf_q      <= ovf_d;
         unf_q      <= unf_d;
      end
   end

   assign bus.pc_out        = pc_out_q;
   assign bus.tid_out       = tid_out_q;
   assign bus.pc_valid      = valid_q;
   assign bus.ras_overflow  = ovf_q;
   assign bus.ras_underflow = unf_q;
endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// tb_pc_sequencer: directed scenarios plus randomized traffic checked against a queue-based reference model.
module tb_pc_sequencer;
   import pc_seq_pkg::*;

   localparam int W  = 6;
   localparam int N  = 4;
   localparam int RD = 2;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   pc_seq_if #(.INST_ADDR_WIDTH(W), .NUM_THREADS(N)) bus ();

   pc_sequencer #(
      .INST_ADDR_WIDTH (W),
      .NUM_THREADS     (N),
      .RAS_DEPTH       (RD),
      .RESET_PC        (0)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // Reference state: one PC per thread, a queue per thread as its return stack.
   int m_pc [N];
   int m_last, m_out, m_tid, m_valid, m_ovf, m_unf;
   int ras [N][$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_step(input bit r, input bit e, input bit st, input logic [N-1:0] te,
                             input bit rv, input int rt, input int rk, input int rp, input int lk);
      int s;
      if (r) begin
         for (int t = 0; t < N; t++) begin
            m_pc[t] = 0;
            ras[t].delete();
         end
         m_last = N - 1; m_out = 0; m_tid = 0; m_valid = 0; m_ovf = 0; m_unf = 0;
         return;
      end
      m_ovf = 0;
      m_unf = 0;
      if (e && !st && te != 0) begin
         s = m_last;
         do s = (s + 1) % N; while (!te[s]);
         m_out     = m_pc[s];
         m_tid     = s;
         m_valid   = 1;
         m_last    = s;
         m_pc[s]   = (m_pc[s] + 1) % (1 << W);
      end else begin
         m_valid = 0;
      end
      if (e && rv && rt < N) begin
`ifdef PC_RAS_EN
         if (rk == 1) begin
            if (ras[rt].size() == RD) begin
               void'(ras[rt].pop_front());
               m_ovf = 1;
            end
            ras[rt].push_back(lk);
            m_pc[rt] = rp;
         end else if (rk == 2) begin
            if (ras[rt].size() > 0) m_pc[rt] = ras[rt].pop_back();
            else begin
               m_pc[rt] = rp;
               m_unf    = 1;
            end
         end else begin
            m_pc[rt] = rp;
         end
`else
         m_pc[rt] = rp;
`endif
      end
   endtask

   task automatic cyc(input bit r, input bit e, input bit st, input logic [N-1:0] te,
                      input bit rv = 0, input int rt = 0, input int rk = 0,
                      input int rp = 0, input int lk = 0);
      @(negedge clk);
      reset              = r;
      bus.en             = e;
      bus.stall          = st;
      bus.thread_en      = te;
      bus.redirect_valid = rv;
      bus.redirect_tid   = rt[1:0];
      bus.redirect_kind  = rk[1:0];
      bus.redirect_pc    = rp[W-1:0];
      bus.link_pc        = lk[W-1:0];
      model_step(r, e, st, te, rv, rt, rk, rp, lk);
      @(posedge clk);
      #1;
      check("pc_valid", 32'(bus.pc_valid), m_valid);
      check("pc_out", 32'(bus.pc_out), m_out);
      check("tid_out", 32'(bus.tid_out), m_tid);
      check("ras_overflow", 32'(bus.ras_overflow), m_ovf);
      check("ras_underflow", 32'(bus.ras_underflow), m_unf);
   endtask

   initial begin
      reset = 1'b1;
      bus.en = 0; bus.stall = 0; bus.thread_en = '0; bus.redirect_valid = 0;
      bus.redirect_tid = '0; bus.redirect_kind = '0; bus.redirect_pc = '0; bus.link_pc = '0;

      cyc(1, 0, 0, 4'b0000);
      cyc(1, 1, 0, 4'b1111);
      check("reset_pc_valid", 32'(bus.pc_valid), 0);

      // Full round robin: (0,0),(1,0),(2,0),(3,0),(0,1),...
      repeat (8) cyc(0, 1, 0, 4'b1111);
      // Alternating subset, then nothing enabled.
      repeat (6) cyc(0, 1, 0, 4'b0101);
      repeat (3) cyc(0, 1, 0, 4'b0000);
      // Thread 1 to 5, then issue it while jumping it to 0x20.
      cyc(0, 1, 0, 4'b0000, 1, 1, 0, 5);
      cyc(0, 1, 0, 4'b0010, 1, 1, 0, 'h20);
      check("same_cycle_issue_pc", 32'(bus.pc_out), 5);
      cyc(0, 1, 0, 4'b0010);
      check("jump_target_pc", 32'(bus.pc_out), 'h20);
      cyc(0, 1, 0, 4'b0010);
      // Call then return on thread 0.
      cyc(0, 1, 0, 4'b0000, 1, 0, 1, 'h30, 'h11);
      repeat (2) cyc(0, 1, 0, 4'b0001);
      cyc(0, 1, 0, 4'b0000, 1, 0, 2, 'h3A);
      repeat (2) cyc(0, 1, 0, 4'b0001);
      // Three calls and three returns on a depth-2 stack.
      cyc(0, 1, 0, 4'b0000, 1, 2, 1, 'h01, 'h0A);
      cyc(0, 1, 0, 4'b0000, 1, 2, 1, 'h02, 'h0B);
      cyc(0, 1, 0, 4'b0000, 1, 2, 1, 'h03, 'h0C);
      cyc(0, 1, 0, 4'b0100);
      cyc(0, 1, 0, 4'b0000, 1, 2, 2, 'h2E);
      cyc(0, 1, 0, 4'b0100);
      cyc(0, 1, 0, 4'b0000, 1, 2, 2, 'h2E);
      cyc(0, 1, 0, 4'b0100);
      cyc(0, 1, 0, 4'b0000, 1, 2, 2, 'h2E);
      cyc(0, 1, 0, 4'b0100);
      // Wrap at 0x3F, then stall with a pending jump.
      cyc(0, 1, 0, 4'b0000, 1, 3, 0, 'h3F);
      repeat (2) cyc(0, 1, 0, 4'b1000);
      check("wrap_pc", 32'(bus.pc_out), 0);
      cyc(0, 1, 1, 4'b1000, 1, 3, 3, 'h15);
      cyc(0, 1, 0, 4'b1000);
      check("stall_jump_pc", 32'(bus.pc_out), 'h15);
      // Disabled core ignores redirects.
      cyc(0, 0, 0, 4'b1111, 1, 0, 0, 'h22);
      repeat (4) cyc(0, 1, 0, 4'b1111);

      for (int i = 0; i < 3000; i++) begin
         cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) != 0), ($urandom_range(0, 4) == 0),
             4'($urandom), ($urandom_range(0, 2) == 0), $urandom_range(0, N - 1),
             $urandom_range(0, 3), $urandom_range(0, 63), $urandom_range(0, 63));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
`default_nettype wire
